redundancy_ctrl: RTL
====================

# redundancy_ctrl

Hardware failover controller for the dual-redundant downstream ports. It decides which of port 1 or port 2 is bridged to the upstream PHY and drives `mux_select`, replacing the direct GPIO bit. It debounces link changes, honours a software force, and changes selection only in an idle gap on the upstream receive path, so frames are not cut. It sits in the `clk` (MCU) domain between the GPIO link/force bits and the `pkt_fifo` resets and TX mux.

## Interface
Parameters:
- `HOLD_CYCLES`, default 12500000: consecutive cycles a link-based switch request must persist (100 ms at 8 ns).
- `IDLE_CYCLES`, default 16: consecutive idle cycles required on `up_busy` before selection changes.
- `DRAIN_TIMEOUT`, default 1250000: maximum cycles spent in DRAIN before a switch is forced.

Ports:
- `clk`  in  1  system clock; sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `link1`  in  1  port 1 link up; synchronous to `clk`.
- `link2`  in  1  port 2 link up; synchronous to `clk`.
- `up_busy`  in  1  upstream rx_dv or tx_en activity, already synchronized to `clk`.
- `force_en`  in  1  software override enable.
- `force_sel`  in  1  forced selection; 0 = port 1, 1 = port 2.
- `revert_en`  in  1  return to port 1 as soon as link1 is stable.
- `select`  out  1  registered mux select; 0 = port 1.
- `switch_pulse`  out  1  one-cycle strobe in the cycle after `select` changes.
- `state`  out  2  current FSM state, for GPIO readback.
- `switch_count`  out  16  number of completed switches; saturates at 16'hFFFF.

## Operation
Desired selection `want` is computed combinationally from the inputs.
- When `force_en`=1: `want` = `force_sel`.
- When `select`=0: `want`=1 iff !link1 & link2.
- When `select`=1: `want`=0 iff link1 & (revert_en | !link2).
- Both links down: `want` = `select`, so the current selection is held.

FSM states, encoded in the package:
- STABLE (0): `select` holds.
  - If `want`≠`select` and `force_en`: go to DRAIN.
  - If `want`≠`select` and not forced: go to HOLD and clear the hold counter.
- HOLD (1): the hold counter increments each cycle `want`≠`select`.
  - If `want`=`select` in any cycle: go back to STABLE (abort).
  - When the counter reaches HOLD_CYCLES-1 with `want` still ≠ `select`: go to DRAIN.
- DRAIN (2): the idle counter increments on each cycle with !`up_busy` and clears on `up_busy`. A separate timeout counter increments every cycle.
  - If `want`=`select` (the request disappears): abort to STABLE.
  - When the idle counter reaches IDLE_CYCLES-1 with !`up_busy`, or the timeout counter reaches DRAIN_TIMEOUT-1: go to SWITCH.
- SWITCH (3): `select` <= ~`select`; `switch_count` increments unless already saturated. Next state is STABLE.

Rules:
- A force asserted while in HOLD moves the FSM to DRAIN on the next cycle.
- A `force_sel` change while in DRAIN re-evaluates `want` and aborts if `want` now equals `select`.
- Counter widths are $clog2 of each parameter, with a minimum of 1. Counters clear on every state entry.

## Timing
Reset values: `select`=0, `state`=STABLE, `switch_pulse`=0, `switch_count`=0, all counters 0.

Output timing:
- `select` toggles on the clock edge that leaves SWITCH.
- `switch_pulse` is high in the first STABLE cycle after that edge.
- `state` is the registered state.

Minimum latency from a `want` change to the `select` toggle, unforced: HOLD_CYCLES + IDLE_CYCLES + 2 cycles. The extra cycles are the STABLE→HOLD entry and the SWITCH state.

Forced latency with no traffic: IDLE_CYCLES + 2 cycles.

Reset asserted mid-operation returns every output to its reset value immediately (asynchronous reset), regardless of state.

## Structure
- Package `redundancy_pkg`: state enumeration (STABLE, HOLD, DRAIN, SWITCH) and port-select constants (SEL_P1=0, SEL_P2=1).
- Sub-module `run_counter`: a saturating consecutive-event counter with parameterized terminal count, `clear` and `inc` inputs, and a `done` output. It is instantiated for the hold, idle and timeout counters.
- The top level instantiates `redundancy_ctrl` with `select` feeding the net currently driven by the GPIO select bit.

## Test plan
All cases use HOLD_CYCLES=4, IDLE_CYCLES=3, DRAIN_TIMEOUT=16.

- **Link failover:** link1 1→0 with link2=1 and `up_busy`=0 → `state` goes HOLD→DRAIN→SWITCH. `select`=1 exactly 9 cycles after link1 falls; `switch_pulse` is high for one cycle; `switch_count`=1.
- **Glitch rejection:** link1 low for 3 cycles, then high → FSM returns to STABLE; `select` stays 0; `switch_count`=0.
- **Packet protection:** request reaches DRAIN while `up_busy` pulses high every 2nd cycle → no switch until the 16-cycle timeout, then `select` toggles. Repeating with a 3-cycle idle gap switches at the end of that gap.
- **Force and revert:** `force_en`=1 with `force_sel`=1 and both links up → `select`=1 after 5 cycles. Then `force_en`=0 with `revert_en`=1 → `select` returns to 0 after 9 cycles.
- **Both links down:** link1=link2=0 → `select` holds and FSM stays STABLE.
- **Reset and saturation:** `rst` asserted mid-DRAIN → all outputs at reset values on the same edge. With `switch_count` preloaded to 16'hFFFF, a further switch leaves it at 16'hFFFF.

Source files
------------

// File: rtl/redundancy_pkg.sv
// redundancy_pkg: shared types and constants for the dual-port failover controller.
package redundancy_pkg;

    // Controller states; the encoding is visible to software through the state readback.
    typedef enum logic [1:0] {
        STABLE = 2'd0,
        HOLD   = 2'd1,
        DRAIN  = 2'd2,
        SWITCH = 2'd3
    } state_e;

    // Mux select values: 0 bridges port 1, 1 bridges port 2.
    localparam logic SEL_P1 = 1'b0;
    localparam logic SEL_P2 = 1'b1;

    // Width needed to count 0..terminal-1, never narrower than one bit.
    function automatic int counterWidth(input int terminal);
        int w;
        w = $clog2(terminal);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/redundancy_ctrl_if.sv
// redundancy_ctrl_if: link/force inputs and select/status outputs of the failover controller.
interface redundancy_ctrl_if;

    logic        link1;
    logic        link2;
    logic        up_busy;
    logic        force_en;
    logic        force_sel;
    logic        revert_en;
    logic        select;
    logic        switch_pulse;
    logic [1:0]  state;
    logic [15:0] switch_count;

    // The GPIO/software side drives link and force bits and reads back status.
    modport master (
        output link1, link2, up_busy, force_en, force_sel, revert_en,
        input  select, switch_pulse, state, switch_count
    );

    // The controller consumes link and force bits and produces the mux select and status.
    modport slave (
        input  link1, link2, up_busy, force_en, force_sel, revert_en,
        output select, switch_pulse, state, switch_count
    );

endinterface

// File: rtl/redundancy_ctrl_run_counter.sv
// run_counter: counts consecutive qualifying cycles and flags the terminal count.
module run_counter
    import redundancy_pkg::*;
#(
    parameter int TERMINAL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic done
);

    localparam int             W    = counterWidth(TERMINAL);
    localparam logic [W-1:0]   LAST = W'(TERMINAL - 1);

    logic [W-1:0] countQ;
    logic [W-1:0] countD;

    // Clear wins over increment; the count parks at the terminal value instead of wrapping.
    always_comb begin
        countD = countQ;
        if (clear) begin
            countD = '0;
        end else if (inc && (countQ != LAST)) begin
            countD = countQ + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            countQ <= '0;
        end else begin
            countQ <= countD;
        end
    end

    assign done = (countQ == LAST);

endmodule

// File: rtl/redundancy_ctrl.sv
// redundancy_ctrl: picks which downstream port feeds the upstream PHY, switching only
// after a debounced request and an idle gap on the upstream receive path.
module redundancy_ctrl
    import redundancy_pkg::*;
#(
    parameter int HOLD_CYCLES   = 12500000,
    parameter int IDLE_CYCLES   = 16,
    parameter int DRAIN_TIMEOUT = 1250000
) (
    input logic              clk,
    input logic              rst,
    redundancy_ctrl_if.slave bus
);

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    state_e      stateQ;
    state_e      stateD;
    logic        selectQ;
    logic        selectD;
    logic        pulseQ;
    logic        pulseD;
    logic [15:0] switchCountQ;
    logic [15:0] switchCountD;

    logic want;
    logic request;
    logic holdClear;
    logic holdInc;
    logic holdDone;
    logic idleClear;
    logic idleInc;
    logic idleDone;
    logic toClear;
    logic toInc;
    logic toDone;

    // Desired port: force wins, otherwise leave a port only when the other one is usable;
    // with both links down the current choice is kept.
    always_comb begin
        want = selectQ;
        if (bus.force_en) begin
            want = bus.force_sel;
        end else if (selectQ == SEL_P1) begin
            want = (!bus.link1 && bus.link2) ? SEL_P2 : SEL_P1;
        end else begin
            want = (bus.link1 && (bus.revert_en || !bus.link2)) ? SEL_P1 : SEL_P2;
        end
    end

    assign request = (want != selectQ);

    // Counters are held at zero outside their own state, so each entry starts fresh.
    assign holdClear = (stateQ != HOLD);
    assign holdInc   = (stateQ == HOLD) && request;
    assign idleClear = (stateQ != DRAIN) || bus.up_busy;
    assign idleInc   = (stateQ == DRAIN) && !bus.up_busy;
    assign toClear   = (stateQ != DRAIN);
    assign toInc     = (stateQ == DRAIN);

    run_counter #(.TERMINAL(HOLD_CYCLES)) uHoldCounter (
        .clk   (clk),
        .rst   (rst),
        .clear (holdClear),
        .inc   (holdInc),
        .done  (holdDone)
    );

    run_counter #(.TERMINAL(IDLE_CYCLES)) uIdleCounter (
        .clk   (clk),
        .rst   (rst),
        .clear (idleClear),
        .inc   (idleInc),
        .done  (idleDone)
    );

    run_counter #(.TERMINAL(DRAIN_TIMEOUT)) uTimeoutCounter (
        .clk   (clk),
        .rst   (rst),
        .clear (toClear),
        .inc   (toInc),
        .done  (toDone)
    );

    // State register together with the registered select, strobe and switch count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ       <= STABLE;
            selectQ      <= SEL_P1;
            pulseQ       <= 1'b0;
            switchCountQ <= '0;
        end else begin
            stateQ       <= stateD;
            selectQ      <= selectD;
            pulseQ       <= pulseD;
            switchCountQ <= switchCountD;
        end
    end

    // Next state: debounce link-driven requests, skip debounce when forced, then wait for idle.
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            STABLE: begin
                if (request) begin
                    stateD = bus.force_en ? DRAIN : HOLD;
                end
            end
            HOLD: begin
                if (!request) begin
                    stateD = STABLE;
                end else if (bus.force_en || holdDone) begin
                    stateD = DRAIN;
                end
            end
            DRAIN: begin
                if (!request) begin
                    stateD = STABLE;
                end else if ((idleDone && !bus.up_busy) || toDone) begin
                    stateD = SWITCH;
                end
            end
            SWITCH: begin
                stateD = STABLE;
            end
            default: begin
                stateD = STABLE;
            end
        endcase
    end

    // Output updates: the select flips and the count advances only when leaving SWITCH.
    always_comb begin
        selectD      = selectQ;
        switchCountD = switchCountQ;
        pulseD       = 1'b0;
        if (stateQ == SWITCH) begin
            selectD = ~selectQ;
            pulseD  = 1'b1;
            if (switchCountQ != COUNT_MAX) begin
                switchCountD = switchCountQ + 16'd1;
            end
        end
    end

    assign bus.select       = selectQ;
    assign bus.switch_pulse = pulseQ;
    assign bus.state        = stateQ;
    assign bus.switch_count = switchCountQ;

endmodule
